// File: rtl/swim_rx_pkg.sv
// rtl/swim_rx_pkg.sv - SWIM receiver state encodings and line timing constants
package swim_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_DATA   = 2'd2,
    ST_PARITY = 2'd3
  } rx_state_e;

  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Nominal low-speed SWIM timing at 48 MHz, shared with the transmitter
  localparam int BIT_PERIOD = 132;
  localparam int SHORT_LOW  = 12;
  localparam int LONG_LOW   = 120;

endpackage

// File: rtl/swim_bit_sampler.sv
// rtl/swim_bit_sampler.sv - pad synchronizer, edge detect and low-pulse classifier
module swim_bit_sampler
  import swim_rx_pkg::*;
#(
  parameter int BIT_THRESH = 66,
  parameter int MIN_LOW    = 3,
  parameter int LINE_RST   = 600
) (
  input  logic clk,
  input  logic reset_n,
  input  logic swim_in,
  output logic fall,
  output logic line_hi,
  output logic bit_stb,
  output logic bit_val,
  output logic glitch,
  output logic lrst_stb
);

  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(BIT_THRESH);
  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_LOW);
  localparam logic [CNT_W-1:0] LRST_C   = CNT_W'(LINE_RST);

  logic             s1_q, s2_q, s3_q;
  logic             fall_q, rise_q;
  logic [CNT_W-1:0] low_cnt_q, low_cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      s3_q      <= 1'b1;
      fall_q    <= 1'b0;
      rise_q    <= 1'b0;
      low_cnt_q <= '0;
    end else begin
      s1_q      <= swim_in;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      fall_q    <= s3_q & ~s2_q;
      rise_q    <= ~s3_q & s2_q;
      low_cnt_q <= low_cnt_d;
    end
  end

  // Loading 1 on fall makes the count at rise equal the pad low width exactly
  always_comb begin
    low_cnt_d = low_cnt_q;
    if (fall_q) begin
      low_cnt_d = CNT_W'(1);
    end else if (!s3_q && low_cnt_q != CNT_MAX) begin
      low_cnt_d = low_cnt_q + 1'b1;
    end
  end

  assign fall     = fall_q;
  assign line_hi  = s3_q;
  assign glitch   = rise_q && (low_cnt_q < MIN_C);
  assign lrst_stb = rise_q && (low_cnt_q >= LRST_C);
  assign bit_stb  = rise_q && !glitch && !lrst_stb;
  assign bit_val  = (low_cnt_q < THRESH_C);

endmodule

// File: rtl/swim_rx.sv
// rtl/swim_rx.sv - SWIM low-speed frame receiver with valid/ready byte output
module swim_rx
  import swim_rx_pkg::*;
#(
  parameter int BIT_THRESH = 66,
  parameter int MIN_LOW    = 3,
  parameter int LINE_RST   = 600,
  parameter int TIMEOUT    = 1023
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_en,
  input  logic       swim_in,
  output logic [7:0] rx_data,
  output logic       rx_perr,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       line_rst,
  output logic       busy
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  rx_state_e        state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [7:0]       data_q;
  logic             perr_q, valid_q, ferr_q, ovr_q, lrst_q;
  logic             fall, line_hi, bit_stb, bit_val, glitch, lrst_stb;
  logic             timeout, done, done_perr, ferr_d;

  swim_bit_sampler #(
    .BIT_THRESH(BIT_THRESH),
    .MIN_LOW   (MIN_LOW),
    .LINE_RST  (LINE_RST)
  ) u_sampler (
    .clk     (clk),
    .reset_n (reset_n),
    .swim_in (swim_in),
    .fall    (fall),
    .line_hi (line_hi),
    .bit_stb (bit_stb),
    .bit_val (bit_val),
    .glitch  (glitch),
    .lrst_stb(lrst_stb)
  );

  assign timeout = (state_q != ST_IDLE) && (hi_cnt_q == TIMEOUT_C);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      shift_q  <= '0;
      hi_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      hi_cnt_q <= hi_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    hi_cnt_d = hi_cnt_q;
    if (state_q == ST_IDLE || fall) begin
      hi_cnt_d = '0;
    end else if (line_hi && hi_cnt_q != CNT_MAX) begin
      hi_cnt_d = hi_cnt_q + 1'b1;
    end
    if (!rx_en || lrst_stb || timeout) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (fall) state_d = ST_START;
        // A sub-threshold pulse after idle was never a start bit
        ST_START: begin
          if (glitch) begin
            state_d = ST_IDLE;
          end else if (bit_stb) begin
            state_d = bit_val ? ST_DATA : ST_IDLE;
            idx_d   = 3'd7;
          end
        end
        ST_DATA: begin
          if (bit_stb) begin
            shift_d = {shift_q[6:0], bit_val};
            idx_d   = idx_q - 3'd1;
            if (idx_q == 3'd0) state_d = ST_PARITY;
          end
        end
        ST_PARITY: if (bit_stb) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    done      = rx_en && !lrst_stb && !timeout && (state_q == ST_PARITY) && bit_stb;
    ferr_d    = rx_en && !lrst_stb &&
                (timeout || ((state_q == ST_START) && bit_stb && !bit_val));
    done_perr = bit_val ^ (^shift_q);
    busy      = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      perr_q  <= 1'b0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      lrst_q  <= 1'b0;
    end else begin
      ferr_q <= ferr_d;
      lrst_q <= lrst_stb;
      ovr_q  <= done && valid_q && !rx_ready;
      if (done && (!valid_q || rx_ready)) begin
        data_q  <= shift_q;
        perr_q  <= done_perr;
        valid_q <= 1'b1;
      end else if (valid_q && rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_data   = data_q;
  assign rx_perr   = perr_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign line_rst  = lrst_q;

endmodule
